parity_frame_tx: RTL and testbench

Serial frame transmitter for the even/odd 0s-and-1s checker.
- Accepts a DATA_W-bit parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Appends a 2-bit trailer so each complete frame holds an even count of 0s and an even count of 1s.
- A downstream even/odd checker therefore returns to S00 at every frame end.
- Sits between a word source and the serial link feeding the checker.

---
 rtl/parity_frame_pkg.sv | 24 ++
 rtl/parity_frame_tx_parity_track.sv | 28 ++
 rtl/parity_frame_tx.sv | 127 ++++++++++++
 tb/tb_parity_frame_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types and parity encoding for the parity frame transmitter and the even/odd checker.
// S-codes: bit1 = odd count of 0s, bit0 = odd count of 1s.
package parity_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TRL0 = 2'd2,
    TRL1 = 2'd3
  } tx_state_t;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  localparam int TRL_LEN = 2;

  // A 0 flips the odd-0s flag, a 1 flips the odd-1s flag.
  function automatic logic [1:0] parity_next(input logic [1:0] s, input logic b);
    parity_next = b ? {s[1], ~s[0]} : {~s[1], s[0]};
  endfunction

endpackage

// File: rtl/parity_frame_tx_parity_track.sv
// Running 0s/1s parity register; advances once per enabled bit.
// Shared with the downstream even/odd checker.
module parity_track
  import parity_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [1:0] o_state
);

  logic [1:0] r_state;

  // Parity advances only on qualified bits; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S00;
    end else if (i_en) begin
      r_state <= parity_next(r_state, i_bit);
    end else begin
      r_state <= r_state;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: shifts a DATA_W-bit word out MSB-first, then adds a 2-bit trailer.
// The trailer keeps both the 0s count and the 1s count of every frame even.
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_sof,
  output logic              tx_eof,
  output logic [1:0]        parity_state
);

  if (((DATA_W % 2) != 0) || (DATA_W < 2)) begin : g_bad_width
    $error("parity_frame_tx: DATA_W must be even and >= 2");
  end

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_p;
  logic              r_in_ready;
  logic              r_tx_bit;
  logic              r_tx_valid;
  logic              r_sof;
  logic              r_eof;
  logic              w_accept;
  logic [1:0]        w_par_state;

  assign w_accept = in_valid & r_in_ready;

  // Outputs are computed one state ahead so each one leaves a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_p        <= 1'b0;
      r_in_ready <= 1'b0;
      r_tx_bit   <= 1'b0;
      r_tx_valid <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, TRL1: begin
          if (w_accept) begin
            r_state    <= DATA;
            r_shift    <= {in_data[DATA_W-2:0], 1'b0};
            r_p        <= ^in_data;
            r_cnt      <= CNT_ONE;
            r_tx_bit   <= in_data[DATA_W-1];
            r_tx_valid <= 1'b1;
            r_sof      <= 1'b1;
            r_eof      <= 1'b0;
            r_in_ready <= 1'b0;
          end else begin
            r_state    <= IDLE;
            r_tx_bit   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        DATA: begin
          r_tx_valid <= 1'b1;
          r_sof      <= 1'b0;
          r_eof      <= 1'b0;
          r_in_ready <= 1'b0;
          if (r_cnt == CNT_LAST) begin
            r_state  <= TRL0;
            r_tx_bit <= 1'b0;
          end else begin
            r_state  <= DATA;
            r_tx_bit <= r_shift[DATA_W-1];
            r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
            r_cnt    <= r_cnt + CNT_ONE;
          end
        end
        TRL0: begin
          // Last bit repairs the 1s parity; with even DATA_W that fixes the 0s too.
          r_state    <= TRL1;
          r_tx_bit   <= r_p;
          r_tx_valid <= 1'b1;
          r_sof      <= 1'b0;
          r_eof      <= 1'b1;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_tx_bit   <= 1'b0;
          r_tx_valid <= 1'b0;
          r_sof      <= 1'b0;
          r_eof      <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  parity_track u_parity_track (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_tx_valid),
    .i_bit   (r_tx_bit),
    .o_state (w_par_state)
  );

  assign in_ready     = r_in_ready;
  assign tx_bit       = r_tx_bit;
  assign tx_valid     = r_tx_valid;
  assign tx_sof       = r_sof;
  assign tx_eof       = r_eof;
  assign parity_state = w_par_state;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed and randomized bench for parity_frame_tx with a bit-counting frame model.
module tb_parity_frame_tx;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx_bit;
  logic       tx_valid;
  logic       tx_sof;
  logic       tx_eof;
  logic [1:0] parity_state;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .tx_bit       (tx_bit),
    .tx_valid     (tx_valid),
    .tx_sof       (tx_sof),
    .tx_eof       (tx_eof),
    .parity_state (parity_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present a word and hold it until accepted (bounded wait).
  task automatic start_word(input logic [7:0] w);
    int k;
    in_data  = w;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      tick;
      k++;
    end
    chk("accept_ready", in_ready, 8'd1);
    tick;
    in_valid = 1'b0;
  endtask

  // Called in the first bit cycle of the frame for w; checks all DATA_W+2 cycles.
  task automatic check_frame(input logic [7:0] w, input logic chain, input logic [7:0] nxt,
                             input logic noise);
    logic [0:9] eb;
    int z;
    int o;
    for (int i = 0; i < 8; i++) eb[i] = w[7-i];
    eb[8] = 1'b0;
    eb[9] = (($countones(w) % 2) == 1);
    z = 0;
    o = 0;
    for (int i = 0; i < 10; i++) begin
      chk("tx_valid", {7'd0, tx_valid}, 8'd1);
      chk("tx_bit", {7'd0, tx_bit}, {7'd0, eb[i]});
      chk("tx_sof", {7'd0, tx_sof}, {7'd0, (i == 0)});
      chk("tx_eof", {7'd0, tx_eof}, {7'd0, (i == 9)});
      chk("in_ready", {7'd0, in_ready}, {7'd0, (i == 9)});
      chk("parity_state", {6'd0, parity_state}, {6'd0, z[0], o[0]});
      if (eb[i]) o++;
      else z++;
      if (i == 9) begin
        in_valid = chain;
        if (chain) in_data = nxt;
      end else if (noise && i >= 1) begin
        in_valid = 1'b1;
        in_data  = 8'h3C;
      end
      tick;
    end
    if (!chain) begin
      in_valid = 1'b0;
      chk("idle_valid", {7'd0, tx_valid}, 8'd0);
      chk("idle_ready", {7'd0, in_ready}, 8'd1);
      chk("checker_s00", {6'd0, parity_state}, 8'd0);
    end
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    logic       ch;

    rst = 1'b0;
    repeat (3) tick;
    chk("rst_valid", {7'd0, tx_valid}, 8'd0);
    chk("rst_bit", {7'd0, tx_bit}, 8'd0);
    chk("rst_sof", {7'd0, tx_sof}, 8'd0);
    chk("rst_eof", {7'd0, tx_eof}, 8'd0);
    chk("rst_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_parity", {6'd0, parity_state}, 8'd0);
    rst = 1'b1;
    tick;
    chk("post_rst_ready", {7'd0, in_ready}, 8'd1);

    start_word(8'hA5);
    check_frame(8'hA5, 1'b0, 8'h00, 1'b0);

    start_word(8'h07);
    check_frame(8'h07, 1'b0, 8'h00, 1'b0);

    start_word(8'hA5);
    check_frame(8'hA5, 1'b1, 8'hFF, 1'b0);
    check_frame(8'hFF, 1'b0, 8'h00, 1'b0);

    // Reset during the 4th data bit abandons the frame.
    start_word(8'hA5);
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("midrst_valid", {7'd0, tx_valid}, 8'd0);
    chk("midrst_bit", {7'd0, tx_bit}, 8'd0);
    chk("midrst_sof", {7'd0, tx_sof}, 8'd0);
    chk("midrst_eof", {7'd0, tx_eof}, 8'd0);
    chk("midrst_ready", {7'd0, in_ready}, 8'd0);
    chk("midrst_parity", {6'd0, parity_state}, 8'd0);
    rst = 1'b1;
    tick;
    chk("midrst_release_ready", {7'd0, in_ready}, 8'd1);
    start_word(8'h5A);
    check_frame(8'h5A, 1'b0, 8'h00, 1'b0);

    start_word(8'h81);
    check_frame(8'h81, 1'b0, 8'h00, 1'b1);

    cur = 8'($urandom);
    start_word(cur);
    for (int n = 0; n < 200; n++) begin
      nxt = 8'($urandom);
      ch  = (n < 199) && ($urandom_range(0, 1) == 1);
      check_frame(cur, ch, nxt, 1'b0);
      if (!ch && n < 199) begin
        repeat ($urandom_range(0, 3)) tick;
        start_word(nxt);
      end
      cur = nxt;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
